inv_key_sched_ctrl: RTL and testbench
=====================================

# inv_key_sched_ctrl

Sequencer for the single-step inverse key-generation datapath used by the AES-128 decryption path. The block takes one 128-bit key and drives the external step combinationally, one round per cycle. It walks the round counter from 9 down to 0 and captures all 11 round keys into a local store. The decryption round engine then reads keys by index through a registered read port.

## Interface
- No parameters. Key width 128 and round count 10 are fixed constants.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `clear`  in  1  synchronous abort; returns the block to IDLE
- `load_valid`  in  1  a key is offered on `load_key`
- `load_key`  in  128  starting key; becomes round-key slot 10
- `load_ready`  out  1  high in IDLE and READY
- `busy`  out  1  high in EXPAND
- `keys_valid`  out  1  high in READY only
- `kg_r_count`  out  4  round index to the step datapath; 4'hF when not in EXPAND
- `kg_key`  out  128  current key to the step datapath
- `kg_keyout`  in  128  combinational step result for (`kg_key`, `kg_r_count`)
- `rk_rd_en`  in  1  read request
- `rk_idx`  in  4  slot to read, 0..10
- `rk_key`  out  128  read data, registered
- `rk_ok`  out  1  registered; high if the request was in range and `keys_valid` was high

## Operation
- State machine: IDLE → EXPAND → READY.
  - IDLE → EXPAND on `load_valid && load_ready`.
  - EXPAND → READY after the step with count 0.
  - READY → EXPAND on a new load.
  - Any state → IDLE on `clear`.
- On load accept:
  - `slot[10] <= load_key`
  - `cur <= load_key`
  - `cnt <= 9`
- Each EXPAND cycle:
  - `kg_key = cur`, `kg_r_count = cnt`.
  - At the clock edge: `slot[cnt] <= kg_keyout`, `cur <= kg_keyout`.
  - If `cnt == 0`, go to READY. Otherwise `cnt <= cnt - 1`.
- Load offered during EXPAND:
  - `load_ready` is 0, so the load is not accepted.
  - The requester must hold `load_valid`.
- Load accepted in READY:
  - `keys_valid` drops on the next cycle.
  - Stored slots are overwritten progressively; old keys are not guaranteed.
- `clear` together with `load_valid`: `clear` wins and the load is not accepted.
- Reads:
  - The read port is always active and returns `slot[rk_idx]` one cycle later.
  - `rk_idx` > 10 returns `rk_key = 0` with `rk_ok = 0`.
  - A read during EXPAND or IDLE returns raw slot contents with `rk_ok = 0`.
- Slot storage is not reset and is not cleared by `clear`.

## Timing
- Load accepted in cycle T:
  - EXPAND occupies cycles T+1..T+10, with `kg_r_count` = 9, 8, …, 0.
  - `keys_valid` is high from T+11.
- Latency from load to all keys valid: 11 cycles. Throughput: one key set per 11 cycles when loads are back-to-back.
- Read issued in cycle R: `rk_key` and `rk_ok` are valid in R+1 and held until the next `rk_rd_en`.
- `clear` or `rst` asserted in cycle C: IDLE in C+1; in-flight expansion is abandoned.
- Reset values:
  - state IDLE
  - `load_ready` 1
  - `busy` 0
  - `keys_valid` 0
  - `kg_r_count` 4'hF
  - `kg_key` 0
  - `rk_key` 0
  - `rk_ok` 0
  - `cnt` 0
- `kg_key` holds its last value outside EXPAND.
- `kg_keyout` must settle within one cycle; the datapath has no internal registers.

## Structure
- Shared package `aes_pkg`:
  - `KEY_W = 128`
  - `NUM_ROUNDS = 10`
  - `RC_IDLE = 4'hF`
  - state enum `ks_state_t` {IDLE, EXPAND, READY}
- One natural sub-module, `round_key_store`:
  - 11×128 register file
  - one write port (index, data, enable)
  - one registered read port with range check
- The step datapath stays outside the block and is connected through the `kg_*` ports.

## Test plan
All scenarios use a bench mock of the step datapath: `kg_keyout = kg_key + 1`.
- **Basic expansion:** load `128'h0` at cycle T. `kg_r_count` reads 9..0 over T+1..T+10 and `keys_valid` rises at T+11. Reading slot i returns `10 - i`; slot 10 returns 0 and slot 0 returns 10, with `rk_ok = 1`.
- **Load during EXPAND:** hold `load_valid` with key `128'hA5` from T+3. The load is accepted at T+11, the first key's results are intact, and the second expansion yields slot 0 = `128'hAF`.
- **Clear mid-run:** assert `clear` at T+5. The block is in IDLE at T+6 with `busy = 0`, `keys_valid = 0`, and `kg_r_count = 4'hF`. A read gives `rk_ok = 0`.
- **Reset mid-run:** assert `rst` at T+4. Every output returns to its reset value at T+5, and a fresh load then completes in 11 cycles.
- **Out-of-range read:** `rk_idx = 11` and `rk_idx = 15` in READY return `rk_key = 0`, `rk_ok = 0`.
- **Clear and load together:** the load is not accepted, the state is IDLE, and `busy` stays 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES-128 inverse key-schedule sequencer.
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int NUM_SLOTS  = NUM_ROUNDS + 1;

  localparam logic [3:0] RC_IDLE  = 4'hF;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_t;

endpackage

// File: rtl/round_key_store.sv
// 11-entry round-key register file: one write port, one registered read port with range check.
module round_key_store
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  input  logic             rd_allow,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_ok
);

  logic [KEY_W-1:0] slot [NUM_SLOTS];
  logic [KEY_W-1:0] rd_key_p1;
  logic             rd_ok_p1;
  logic             rd_in_range;

  assign rd_in_range = (rd_idx <= LAST_IDX);

  // Storage carries no reset; contents survive rst and clear.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx <= LAST_IDX)) begin
      slot[wr_idx] <= wr_key;
    end
  end

  // Read stage: result held until the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_p1 <= '0;
      rd_ok_p1  <= 1'b0;
    end else if (rd_en) begin
      rd_key_p1 <= rd_in_range ? slot[rd_idx] : '0;
      rd_ok_p1  <= rd_in_range && rd_allow;
    end
  end

  assign rd_key = rd_key_p1;
  assign rd_ok  = rd_ok_p1;

endmodule

// File: rtl/inv_key_sched_ctrl.sv
// Drives an external single-step inverse key-generation datapath for rounds 9..0 and
// captures all 11 round keys for the decryption round engine.
module inv_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [KEY_W-1:0] load_key,
  output logic             load_ready,
  output logic             busy,
  output logic             keys_valid,
  output logic [3:0]       kg_r_count,
  output logic [KEY_W-1:0] kg_key,
  input  logic [KEY_W-1:0] kg_keyout,
  input  logic             rk_rd_en,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_key,
  output logic             rk_ok
);

  ks_state_t        state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [KEY_W-1:0] cur, cur_nxt;
  logic             load_acc;
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic [KEY_W-1:0] wr_key;

  assign load_ready = (state == IDLE) || (state == READY);
  assign busy       = (state == EXPAND);
  assign keys_valid = (state == READY);
  assign kg_r_count = busy ? cnt : RC_IDLE;
  assign kg_key     = cur;

  // clear outranks a simultaneous load offer.
  assign load_acc = load_valid && load_ready && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cur   <= cur_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur;
    wr_en     = 1'b0;
    wr_idx    = cnt;
    wr_key    = kg_keyout;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, READY: begin
          if (load_acc) begin
            state_nxt = EXPAND;
            cnt_nxt   = LAST_IDX - 4'd1;
            cur_nxt   = load_key;
            wr_en     = 1'b1;
            wr_idx    = LAST_IDX;
            wr_key    = load_key;
          end
        end
        EXPAND: begin
          wr_en   = 1'b1;
          cur_nxt = kg_keyout;
          if (cnt == 4'd0) begin
            state_nxt = READY;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  round_key_store u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_key   (wr_key),
    .rd_en    (rk_rd_en),
    .rd_idx   (rk_idx),
    .rd_allow (keys_valid),
    .rd_key   (rk_key),
    .rd_ok    (rk_ok)
  );

endmodule

// File: tb/tb_inv_key_sched_ctrl.sv
// Self-checking bench for inv_key_sched_ctrl with an increment-by-one step datapath mock.
module tb_inv_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst, clear, load_valid;
  logic [127:0] load_key;
  logic         load_ready, busy, keys_valid;
  logic [3:0]   kg_r_count;
  logic [127:0] kg_key, kg_keyout;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic [127:0] rk_key;
  logic         rk_ok;

  int checks = 0;
  int errors = 0;

  // Reference model: slot contents derived directly from the expansion rule.
  logic [127:0] exp_slot [11];

  always #5 clk = ~clk;

  assign kg_keyout = kg_key + 128'd1;

  inv_key_sched_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load_valid (load_valid),
    .load_key   (load_key),
    .load_ready (load_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .kg_r_count (kg_r_count),
    .kg_key     (kg_key),
    .kg_keyout  (kg_keyout),
    .rk_rd_en   (rk_rd_en),
    .rk_idx     (rk_idx),
    .rk_key     (rk_key),
    .rk_ok      (rk_ok)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Slot 10 is the loaded key; step s (0-based) writes slot 9-s with key+s+1.
  task automatic model_expand(input logic [127:0] key, input int nsteps);
    exp_slot[10] = key;
    for (int s = 0; s < nsteps; s++) exp_slot[9-s] = key + 128'(s + 1);
  endtask

  task automatic start_load(input logic [127:0] key);
    load_valid = 1'b1;
    load_key   = key;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; load_valid = 1'b0; load_key = '0;
    rk_rd_en = 1'b0; rk_idx = '0;
    tick(); tick();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %0b want 1", load_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid: got %0b want 0", keys_valid); end
    checks++; if (kg_r_count !== 4'hF) begin errors++; $display("FAIL reset_kg_r_count: got %h want f", kg_r_count); end
    checks++; if (kg_key !== 128'h0) begin errors++; $display("FAIL reset_kg_key: got %h want 0", kg_key); end
    checks++; if (rk_key !== 128'h0) begin errors++; $display("FAIL reset_rk_key: got %h want 0", rk_key); end
    checks++; if (rk_ok !== 1'b0) begin errors++; $display("FAIL reset_rk_ok: got %0b want 0", rk_ok); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start_load(128'h0);
    for (int c = 9; c >= 0; c--) begin
      checks++; if (busy !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL basic_busy c=%0d: got busy=%0b ready=%0b want 1/0", c, busy, load_ready); end
      checks++; if (kg_r_count !== 4'(c)) begin errors++; $display("FAIL basic_count: got %0d want %0d", kg_r_count, c); end
      checks++; if (kg_key !== 128'(9 - c)) begin errors++; $display("FAIL basic_kg_key c=%0d: got %h want %h", c, kg_key, 128'(9 - c)); end
      tick();
    end
    checks++; if (keys_valid !== 1'b1 || busy !== 1'b0 || kg_r_count !== 4'hF) begin errors++; $display("FAIL basic_ready: got kv=%0b busy=%0b cnt=%h want 1/0/f", keys_valid, busy, kg_r_count); end
    model_expand(128'h0, 10);
    for (int i = 0; i <= 10; i++) begin
      rk_rd_en = 1'b1; rk_idx = 4'(i);
      tick();
      checks++; if (rk_key !== 128'(10 - i) || rk_ok !== 1'b1) begin errors++; $display("FAIL basic_read slot%0d: got %h ok=%0b want %h ok=1", i, rk_key, rk_ok, 128'(10 - i)); end
    end
    rk_rd_en = 1'b0; rk_idx = 4'd3;
    tick();
    checks++; if (rk_key !== exp_slot[10]) begin errors++; $display("FAIL read_hold: got %h want %h", rk_key, exp_slot[10]); end
  endtask

  task automatic test_random();
    logic [127:0] key;
    int idx;
    for (int n = 0; n < 3; n++) begin
      key = rand_key();
      start_load(key);
      checks++; if (keys_valid !== 1'b0) begin errors++; $display("FAIL rand_kv_drop: got %0b want 0", keys_valid); end
      for (int c = 9; c >= 0; c--) begin
        checks++; if (kg_r_count !== 4'(c) || kg_key !== key + 128'(9 - c)) begin errors++; $display("FAIL rand_step c=%0d: got cnt=%0d key=%h want %h", c, kg_r_count, kg_key, key + 128'(9 - c)); end
        tick();
      end
      checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL rand_kv: got %0b want 1", keys_valid); end
      model_expand(key, 10);
      for (int r = 0; r < 6; r++) begin
        idx = $urandom_range(0, 15);
        rk_rd_en = 1'b1; rk_idx = 4'(idx);
        tick();
        checks++;
        if (rk_key !== ((idx <= 10) ? exp_slot[idx] : 128'h0) || rk_ok !== (idx <= 10)) begin
          errors++; $display("FAIL rand_read idx=%0d: got %h ok=%0b", idx, rk_key, rk_ok);
        end
      end
      rk_rd_en = 1'b0;
    end
  endtask

  task automatic test_load_during_expand();
    logic [127:0] k1;
    k1 = rand_key();
    start_load(k1);
    tick(); tick();
    load_valid = 1'b1; load_key = 128'hA5;
    for (int t = 3; t <= 10; t++) begin
      checks++; if (load_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lde_stall T+%0d: got ready=%0b busy=%0b want 0/1", t, load_ready, busy); end
      tick();
    end
    checks++; if (keys_valid !== 1'b1 || load_ready !== 1'b1) begin errors++; $display("FAIL lde_ready: got kv=%0b ready=%0b want 1/1", keys_valid, load_ready); end
    model_expand(k1, 10);
    rk_rd_en = 1'b1; rk_idx = 4'd0;
    tick();
    load_valid = 1'b0; rk_rd_en = 1'b0;
    checks++; if (rk_key !== exp_slot[0] || rk_ok !== 1'b1) begin errors++; $display("FAIL lde_first_intact: got %h ok=%0b want %h ok=1", rk_key, rk_ok, exp_slot[0]); end
    checks++; if (busy !== 1'b1 || kg_r_count !== 4'd9 || kg_key !== 128'hA5) begin errors++; $display("FAIL lde_accept: got busy=%0b cnt=%0d key=%h want 1/9/a5", busy, kg_r_count, kg_key); end
    for (int t = 0; t < 10; t++) tick();
    model_expand(128'hA5, 10);
    rk_rd_en = 1'b1; rk_idx = 4'd0;
    tick();
    rk_rd_en = 1'b0;
    checks++; if (rk_key !== 128'hAF || rk_key !== exp_slot[0] || rk_ok !== 1'b1) begin errors++; $display("FAIL lde_second_slot0: got %h ok=%0b want af ok=1", rk_key, rk_ok); end
  endtask

  task automatic test_clear();
    logic [127:0] key;
    key = rand_key();
    start_load(key);
    tick(); tick(); tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (busy !== 1'b0 || keys_valid !== 1'b0 || kg_r_count !== 4'hF || load_ready !== 1'b1) begin errors++; $display("FAIL clear_idle: got busy=%0b kv=%0b cnt=%h ready=%0b", busy, keys_valid, kg_r_count, load_ready); end
    model_expand(key, 4);
    rk_rd_en = 1'b1; rk_idx = 4'd10;
    tick();
    checks++; if (rk_key !== exp_slot[10] || rk_ok !== 1'b0) begin errors++; $display("FAIL clear_read10: got %h ok=%0b want %h ok=0", rk_key, rk_ok, exp_slot[10]); end
    rk_idx = 4'd6;
    tick();
    rk_rd_en = 1'b0;
    checks++; if (rk_key !== exp_slot[6] || rk_ok !== 1'b0) begin errors++; $display("FAIL clear_read6: got %h ok=%0b want %h ok=0", rk_key, rk_ok, exp_slot[6]); end
  endtask

  task automatic test_reset_mid(output logic [127:0] key2);
    logic [127:0] key;
    key = rand_key();
    start_load(key);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (load_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0 || kg_r_count !== 4'hF) begin errors++; $display("FAIL rstmid_ctrl: got ready=%0b busy=%0b kv=%0b cnt=%h", load_ready, busy, keys_valid, kg_r_count); end
    checks++; if (kg_key !== 128'h0 || rk_key !== 128'h0 || rk_ok !== 1'b0) begin errors++; $display("FAIL rstmid_data: got kg_key=%h rk_key=%h ok=%0b want 0", kg_key, rk_key, rk_ok); end
    key2 = rand_key();
    start_load(key2);
    for (int c = 9; c >= 0; c--) begin
      checks++; if (busy !== 1'b1 || kg_r_count !== 4'(c)) begin errors++; $display("FAIL rstmid_expand c=%0d: got busy=%0b cnt=%0d", c, busy, kg_r_count); end
      tick();
    end
    checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL rstmid_kv: got %0b want 1", keys_valid); end
    model_expand(key2, 10);
    rk_rd_en = 1'b1; rk_idx = 4'd0;
    tick();
    rk_rd_en = 1'b0;
    checks++; if (rk_key !== exp_slot[0] || rk_ok !== 1'b1) begin errors++; $display("FAIL rstmid_slot0: got %h ok=%0b want %h ok=1", rk_key, rk_ok, exp_slot[0]); end
  endtask

  task automatic test_out_of_range();
    logic [3:0] idxs [3];
    idxs[0] = 4'd10; idxs[1] = 4'd11; idxs[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      rk_rd_en = 1'b1; rk_idx = idxs[i];
      tick();
      checks++;
      if (rk_key !== ((idxs[i] == 4'd10) ? exp_slot[10] : 128'h0) || rk_ok !== (idxs[i] == 4'd10)) begin
        errors++; $display("FAIL oor_read idx=%0d: got %h ok=%0b", idxs[i], rk_key, rk_ok);
      end
    end
    rk_rd_en = 1'b0;
  endtask

  task automatic test_clear_and_load(input logic [127:0] key2);
    clear = 1'b1; load_valid = 1'b1; load_key = rand_key();
    tick();
    clear = 1'b0; load_valid = 1'b0;
    checks++; if (busy !== 1'b0 || keys_valid !== 1'b0 || kg_r_count !== 4'hF || load_ready !== 1'b1) begin errors++; $display("FAIL cl_idle: got busy=%0b kv=%0b cnt=%h ready=%0b", busy, keys_valid, kg_r_count, load_ready); end
    checks++; if (kg_key !== key2 + 128'd10) begin errors++; $display("FAIL cl_kg_key_held: got %h want %h", kg_key, key2 + 128'd10); end
    rk_rd_en = 1'b1; rk_idx = 4'd10;
    tick();
    rk_rd_en = 1'b0;
    checks++; if (busy !== 1'b0 || rk_key !== key2 || rk_ok !== 1'b0) begin errors++; $display("FAIL cl_no_load: got busy=%0b slot10=%h ok=%0b want 0/%h/0", busy, rk_key, rk_ok, key2); end
  endtask

  initial begin
    logic [127:0] key2;
    test_reset();
    test_basic();
    test_random();
    test_load_during_expand();
    test_clear();
    test_reset_mid(key2);
    test_out_of_range();
    test_clear_and_load(key2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
